cpu_loader: RTL

- Boot sequencer for the SCAMP CPU.
- Holds the CPU in reset while a 16-bit word stream is written into program RAM from LOAD_BASE upward. Then releases CPU reset and hands the RAM port to the CPU.
- Sits between the top level, the CPU, and the single-port RAM. Owns the RAM address/data/write lines and the CPU reset_bar.

---
 rtl/cpu_loader_pkg.sv | 14 +
 rtl/cpu_loader_if.sv | 23 ++
 rtl/cpu_loader_hold_counter.sv | 36 +++
 rtl/cpu_loader.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cpu_loader_pkg.sv
// rtl/cpu_loader_pkg.sv - shared state encoding for the SCAMP boot loader
package cpu_loader_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

endpackage

// File: rtl/cpu_loader_if.sv
// rtl/cpu_loader_if.sv - 16-bit word stream feeding the boot loader
interface cpu_loader_if;

    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/cpu_loader_hold_counter.sv
// rtl/cpu_loader_hold_counter.sv - loadable down-counter with terminal flag for reset stretching
module cpu_loader_hold_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             terminal
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Stops at zero so an idle counter never wraps into a false terminal.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminal = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/cpu_loader.sv
// rtl/cpu_loader.sv - boot sequencer: streams words into program RAM, then releases the CPU
module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter logic [15:0] LOAD_BASE  = 16'h0000,
    parameter int          MAX_WORDS  = 4096,
    parameter int          RESET_HOLD = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    cpu_loader_if.slave  in_if,
    input  logic [15:0]  cpu_addr,
    input  logic [15:0]  cpu_wdata,
    input  logic         cpu_we,
    output logic [15:0]  mem_addr,
    output logic [15:0]  mem_wdata,
    output logic         mem_we,
    output logic         cpu_reset_bar,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [15:0]  count
);

    localparam logic [16:0] MAX_CNT = 17'(MAX_WORDS);

    state_e      state_q, state_d;
    logic [16:0] count_q, count_d;
    logic        error_q, error_d;
    logic [15:0] ld_addr_q;
    logic [15:0] ld_wdata_q;
    logic        ld_we_q;
    logic        rst_bar_q;
    logic        busy_q;
    logic        done_q;

    logic accept;
    logic write_d;
    logic hold_load;
    logic hold_done;

    assign accept    = in_if.in_valid && (state_q == ST_LOAD);
    assign write_d   = accept && !start;
    assign hold_load = write_d && in_if.in_last;

    cpu_loader_hold_counter #(
        .WIDTH(16)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (hold_load),
        .load_value (16'(RESET_HOLD)),
        .dec        (state_q == ST_HOLD),
        .terminal   (hold_done)
    );

    // A start in LOAD restarts the load; any word accepted alongside it is dropped.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        error_d = error_q;
        if (start) begin
            state_d = ST_LOAD;
            count_d = '0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        if (count_q != MAX_CNT) begin
                            count_d = count_q + 17'd1;
                        end
                        if (in_if.in_last) begin
                            state_d = ST_HOLD;
                        end else if (count_q == MAX_CNT - 17'd1) begin
                            state_d = ST_ERROR;
                            error_d = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_done) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            error_q    <= 1'b0;
            ld_addr_q  <= '0;
            ld_wdata_q <= '0;
            ld_we_q    <= 1'b0;
            rst_bar_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            error_q   <= error_d;
            ld_we_q   <= write_d;
            if (write_d) begin
                ld_addr_q  <= LOAD_BASE + count_q[15:0];
                ld_wdata_q <= in_if.in_data;
            end
            rst_bar_q <= (state_d == ST_RUN);
            busy_q    <= (state_d == ST_LOAD) || (state_d == ST_HOLD);
            done_q    <= (state_d == ST_RUN);
        end
    end

    assign in_if.in_ready = (state_q == ST_LOAD);

    // RAM port belongs to the CPU only while it is running.
    assign mem_addr  = (state_q == ST_RUN) ? cpu_addr  : ld_addr_q;
    assign mem_wdata = (state_q == ST_RUN) ? cpu_wdata : ld_wdata_q;
    assign mem_we    = (state_q == ST_RUN) ? cpu_we    : ld_we_q;

    assign cpu_reset_bar = rst_bar_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    // 65536 words cannot be shown in 16 bits; pin the visible count at all-ones instead of wrapping.
    assign count         = count_q[16] ? 16'hFFFF : count_q[15:0];

endmodule
